// File: rtl/ps2_rx_multi_pkg.sv
// ps2_pkg: shared FSM state type, frame constants and width helper for ps2_rx_multi.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam int FRAME_DATA_BITS = 8;
   function automatic int chan_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/ps2_rx_chan.sv
// ps2_rx_chan: one PS/2 device-to-host port: synchroniser, clock glitch filter, frame FSM.
// The frame watchdog is compiled in only when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx_chan import ps2_pkg::*; #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_ps2_clk,
   input  logic                       i_ps2_data,
   output logic                       o_push,
   output logic [FRAME_DATA_BITS-1:0] o_byte,
   output logic                       o_err_parity,
   output logic                       o_err_frame
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   logic [1:0]                 r_clk_s, r_dat_s;
   logic                       r_fclk, r_fclk_d;
   logic [FW-1:0]              r_fcnt;
   state_t                     r_state;
   logic [2:0]                 r_cnt;
   logic [FRAME_DATA_BITS-1:0] r_shift;
   logic                       r_par;
   logic                       w_strobe, w_bit, w_par_ok, w_timeout;
   assign w_strobe = r_fclk_d & ~r_fclk;
   assign w_bit    = r_dat_s[1];
   assign w_par_ok = ^{r_shift, r_par};
   assign o_push   = w_strobe && r_state == STOP && w_bit && w_par_ok;
   assign o_byte   = r_shift;
   // Filtered clock flips only after FILTER_LEN consecutive samples at the opposite level.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s  <= 2'b11;
         r_dat_s  <= 2'b11;
         r_fclk   <= 1'b1;
         r_fclk_d <= 1'b1;
         r_fcnt   <= '0;
      end else begin
         r_clk_s  <= {r_clk_s[0], i_ps2_clk};
         r_dat_s  <= {r_dat_s[0], i_ps2_data};
         r_fclk_d <= r_fclk;
         if (r_clk_s[1] == r_fclk) r_fcnt <= '0;
         else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
            r_fclk <= ~r_fclk;
            r_fcnt <= '0;
         end else r_fcnt <= r_fcnt + FW'(1);
      end
   end
`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tcnt;
   always_ff @(posedge clk) begin
      if (reset || r_state == IDLE || w_strobe) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + TW'(1);
   end
   assign w_timeout = r_state != IDLE && !w_strobe && r_tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
   assign w_timeout = TIMEOUT_CYCLES < 0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         o_err_parity <= 1'b0;
         o_err_frame  <= 1'b0;
      end else begin
         o_err_parity <= 1'b0;
         o_err_frame  <= 1'b0;
         if (w_strobe) begin
            case (r_state)
               IDLE: if (!w_bit) begin
                  r_state <= DATA;
                  r_cnt   <= '0;
               end
               DATA: begin
                  r_shift <= {w_bit, r_shift[FRAME_DATA_BITS-1:1]};
                  r_cnt   <= r_cnt + 3'd1;
                  if (r_cnt == 3'(FRAME_DATA_BITS - 1)) r_state <= PARITY;
               end
               PARITY: begin
                  r_par   <= w_bit;
                  r_state <= STOP;
               end
               default: begin
                  o_err_frame  <= !w_bit;
                  o_err_parity <= w_bit && !w_par_ok;
                  r_state      <= IDLE;
               end
            endcase
         end else if (w_timeout) begin
            r_state     <= IDLE;
            o_err_frame <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/ps2_rx_multi.sv
// ps2_rx_multi: CHANNELS-port PS/2 host receiver, per-channel FIFOs merged round-robin onto one stream.
// Define PS2_RX_TIMEOUT_EN to enable the per-channel frame watchdog.
module ps2_rx_multi import ps2_pkg::*; #(
   parameter  int CHANNELS       = 2,
   parameter  int FIFO_DEPTH     = 4,
   parameter  int FILTER_LEN     = 4,
   parameter  int TIMEOUT_CYCLES = 2500,
   localparam int CW             = chan_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] ps2_clk,
   input  logic [CHANNELS-1:0] ps2_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [7:0]          out_data,
   output logic [CW-1:0]       out_chan,
   output logic [CHANNELS-1:0] err_parity,
   output logic [CHANNELS-1:0] err_frame,
   output logic [CHANNELS-1:0] overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [CHANNELS-1:0]   w_ne;
   logic [2*CHANNELS-1:0] w_rot;
   logic [7:0]            w_head [CHANNELS];
   logic [CW-1:0]         w_off, w_pick, w_grant, r_gchan, r_rr;
   logic [CW:0]           w_sum;
   logic                  r_hold, w_xfer;
   assign out_valid = |w_ne;
   assign w_xfer    = out_valid && out_ready;
   assign w_grant   = r_hold ? r_gchan : w_pick;
   assign out_chan  = w_grant;
   assign out_data  = out_valid ? w_head[w_grant] : 8'h00;
   // Rotate so bit 0 is the channel after the last grant, then take the lowest non-empty.
   assign w_rot = {w_ne, w_ne} >> r_rr;
   always_comb begin
      w_off = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) if (w_rot[i]) w_off = CW'(i);
   end
   assign w_sum  = {1'b0, r_rr} + {1'b0, w_off};
   assign w_pick = (w_sum >= (CW+1)'(CHANNELS)) ? CW'(w_sum - (CW+1)'(CHANNELS)) : w_sum[CW-1:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold  <= 1'b0;
         r_gchan <= '0;
         r_rr    <= '0;
      end else begin
         r_hold  <= out_valid && !out_ready;
         r_gchan <= w_grant;
         if (w_xfer) r_rr <= (w_grant == CW'(CHANNELS - 1)) ? '0 : w_grant + CW'(1);
      end
   end
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [7:0]  r_mem [FIFO_DEPTH];
      logic [7:0]  w_byte;
      logic [AW:0] r_wp, r_rp;
      logic        r_ovf, w_push, w_full, w_pop, w_wr;
      ps2_rx_chan #(
         .FILTER_LEN    (FILTER_LEN),
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .i_ps2_clk   (ps2_clk[g]),
         .i_ps2_data  (ps2_data[g]),
         .o_push      (w_push),
         .o_byte      (w_byte),
         .o_err_parity(err_parity[g]),
         .o_err_frame (err_frame[g])
      );
      assign w_full      = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
      assign w_pop       = w_xfer && w_grant == CW'(g);
      assign w_wr        = w_push && (!w_full || w_pop);
      assign w_ne[g]     = r_wp != r_rp;
      assign w_head[g]   = r_mem[r_rp[AW-1:0]];
      assign overflow[g] = r_ovf;
      always_ff @(posedge clk) begin
         if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
         end else begin
            r_ovf <= w_push && w_full && !w_pop;
            if (w_wr) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop) r_rp <= r_rp + (AW+1)'(1);
         end
      end
      always_ff @(posedge clk) if (w_wr) r_mem[r_wp[AW-1:0]] <= w_byte;
   end
endmodule

// File: tb/tb_ps2_rx_multi.sv
// tb_ps2_rx_multi: scoreboard bench for ps2_rx_multi (2 channels, depth 4, filter 4).
// Watchdog scenario runs only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_multi;
   localparam int CH   = 2;
   localparam int HALF = 20;
   localparam int TMO  = 2500;
   logic          clk = 1'b0, reset = 1'b1, out_ready = 1'b1;
   logic [CH-1:0] ps2_clk = '1, ps2_data = '1;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [0:0]    out_chan;
   logic [CH-1:0] err_parity, err_frame, overflow;
   ps2_rx_multi #(
      .CHANNELS(CH), .FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
      .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;
   logic [8:0] exp_q[$], obs_q[$];
   int ep_cnt[CH], ef_cnt[CH], ov_cnt[CH], ef_cyc[CH];
   int long_cnt = 0, stall_viol = 0, compared = 0, mismatched = 0, last_fall = 0;
   logic          prev_stall = 1'b0;
   logic [8:0]    prev_out = '0;
   logic [CH-1:0] prev_ep = '0, prev_ef = '0, prev_ov = '0;
   initial for (int c = 0; c < CH; c++) begin
      ep_cnt[c] = 0; ef_cnt[c] = 0; ov_cnt[c] = 0; ef_cyc[c] = 0;
   end
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid && out_ready) obs_q.push_back({out_chan, out_data});
         if (prev_stall && {out_chan, out_data} !== prev_out) stall_viol++;
         for (int c = 0; c < CH; c++) begin
            if (err_parity[c]) ep_cnt[c]++;
            if (err_frame[c]) begin ef_cnt[c]++; ef_cyc[c] = cyc; end
            if (overflow[c]) ov_cnt[c]++;
         end
         if (|(prev_ep & err_parity) || |(prev_ef & err_frame) || |(prev_ov & overflow)) long_cnt++;
      end
      prev_stall = !reset && out_valid && !out_ready;
      prev_out   = {out_chan, out_data};
      prev_ep    = err_parity;
      prev_ef    = err_frame;
      prev_ov    = overflow;
   end
   task automatic send_frame(input int ch, input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits, input bit exp_out);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      if (exp_out) exp_q.push_back({ch[0], b});
      for (int i = 0; i < nbits; i++) begin
         ps2_data[ch] = bits[i];
         repeat (HALF) @(posedge clk); #1;
         ps2_clk[ch] = 1'b0;
         last_fall = cyc;
         repeat (HALF) @(posedge clk); #1;
         ps2_clk[ch] = 1'b1;
      end
      ps2_data[ch] = 1'b1;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_out got v=%b d=%h c=%b want 0/00/0", out_valid, out_data, out_chan);
      end
      compared++;
      if ({err_parity, err_frame, overflow} !== '0) begin
         mismatched++;
         $display("FAIL reset_err got %b want 0", {err_parity, err_frame, overflow});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_idle_valid got %b want 0", out_valid);
      end
   endtask
   task automatic test_good;
      int ep0, ef0;
      logic [8:0] e, o;
      ep0 = ep_cnt[0]; ef0 = ef_cnt[0];
      out_ready = 1'b1;
      send_frame(0, 8'h1C, 0, 0, 11, 1);
      repeat (10) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL good_byte got %h want %h", o, e); end
      end
      compared++;
      if (obs_q.size() != 0 || ep_cnt[0] != ep0 || ef_cnt[0] != ef0) begin
         mismatched++;
         $display("FAIL good_extra got extra=%0d perr=%0d ferr=%0d want 0/0/0",
                  obs_q.size(), ep_cnt[0] - ep0, ef_cnt[0] - ef0);
         obs_q.delete();
      end
   endtask
   task automatic test_parity;
      int ep0, ef0;
      ep0 = ep_cnt[0]; ef0 = ef_cnt[0];
      send_frame(0, 8'hF0, 1, 0, 11, 0);
      repeat (10) @(posedge clk);
      compared++;
      if (ep_cnt[0] != ep0 + 1 || ef_cnt[0] != ef0) begin
         mismatched++;
         $display("FAIL parity_err got perr=%0d ferr=%0d want 1/0", ep_cnt[0] - ep0, ef_cnt[0] - ef0);
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL parity_drop got %0d bytes want 0", obs_q.size());
         obs_q.delete();
      end
   endtask
   task automatic test_frame;
      int ep1, ef1;
      ep1 = ep_cnt[1]; ef1 = ef_cnt[1];
      send_frame(1, 8'h5A, 1, 1, 11, 0);
      repeat (10) @(posedge clk);
      compared++;
      if (ef_cnt[1] != ef1 + 1 || ep_cnt[1] != ep1) begin
         mismatched++;
         $display("FAIL frame_err got ferr=%0d perr=%0d want 1/0", ef_cnt[1] - ef1, ep_cnt[1] - ep1);
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL frame_drop got %0d bytes want 0", obs_q.size());
         obs_q.delete();
      end
   endtask
   task automatic test_overflow;
      int ov0;
      logic [8:0] e, o;
      ov0 = ov_cnt[0];
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(0, 8'hA1 + 8'(i), 0, 0, 11, i < 4);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compared++;
      if (ov_cnt[0] != ov0 + 1) begin
         mismatched++;
         $display("FAIL overflow_pulse got %0d want 1", ov_cnt[0] - ov0);
      end
      compared++;
      if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
         mismatched++;
         $display("FAIL overflow_head got v=%b d=%h want 1/a1", out_valid, out_data);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL overflow_byte got %h want %h", o, e); end
      end
      compared++;
      if (obs_q.size() != 0) begin
         mismatched++;
         $display("FAIL overflow_extra got %0d extra bytes want 0", obs_q.size());
         obs_q.delete();
      end
   endtask
   task automatic test_round_robin;
      logic [8:0] e, o;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b0;
      send_frame(0, 8'h11, 0, 0, 11, 0);
      send_frame(0, 8'h22, 0, 0, 11, 0);
      send_frame(1, 8'h33, 0, 0, 11, 0);
      send_frame(1, 8'h44, 0, 0, 11, 0);
      exp_q.push_back(9'h011);
      exp_q.push_back(9'h133);
      exp_q.push_back(9'h022);
      exp_q.push_back(9'h144);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || out_chan !== 1'b0 || out_data !== 8'h11) begin
         mismatched++;
         $display("FAIL rr_stall_head got v=%b c=%b d=%h want 1/0/11", out_valid, out_chan, out_data);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL rr_byte got %h want %h", o, e); end
      end
      @(negedge clk);
      compared++;
      if (obs_q.size() != 0 || out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL rr_drain got extra=%0d valid=%b want 0/0", obs_q.size(), out_valid);
         obs_q.delete();
      end
      compared++;
      if (stall_viol != 0 || long_cnt != 0) begin
         mismatched++;
         $display("FAIL hold_and_pulse got stall=%0d long=%0d want 0/0", stall_viol, long_cnt);
      end
   endtask
   task automatic test_glitch;
      int ep0, ef0;
      logic [8:0] e, o;
      ep0 = ep_cnt[0]; ef0 = ef_cnt[0];
      @(posedge clk); #1;
      ps2_data[0] = 1'b0;
      ps2_clk[0]  = 1'b0;
      @(posedge clk); #1;
      ps2_clk[0]  = 1'b1;
      repeat (HALF) @(posedge clk); #1;
      ps2_data[0] = 1'b1;
      send_frame(0, 8'h3A, 0, 0, 11, 1);
      repeat (10) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL glitch_byte got %h want %h", o, e); end
      end
      compared++;
      if (obs_q.size() != 0 || ep_cnt[0] != ep0 || ef_cnt[0] != ef0) begin
         mismatched++;
         $display("FAIL glitch_clean got extra=%0d perr=%0d ferr=%0d want 0/0/0",
                  obs_q.size(), ep_cnt[0] - ep0, ef_cnt[0] - ef0);
         obs_q.delete();
      end
   endtask
`ifdef PS2_RX_TIMEOUT_EN
   task automatic test_timeout;
      int ef0, t0, dt;
      logic [8:0] e, o;
      ef0 = ef_cnt[0];
      send_frame(0, 8'h0F, 0, 0, 5, 0);
      t0 = last_fall;
      for (int k = 0; k < TMO + 200 && ef_cnt[0] == ef0; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      dt = ef_cyc[0] - t0;
      compared++;
      if (ef_cnt[0] != ef0 + 1 || dt < TMO || dt > TMO + 30) begin
         mismatched++;
         $display("FAIL timeout_err got count=%0d delay=%0d want 1 within [%0d,%0d]",
                  ef_cnt[0] - ef0, dt, TMO, TMO + 30);
      end
      send_frame(0, 8'h55, 0, 0, 11, 1);
      repeat (10) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
         compared++;
         if (o !== e) begin mismatched++; $display("FAIL timeout_next got %h want %h", o, e); end
      end
   endtask
`endif
   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "bench timed out");
   end
   initial begin
      test_reset();
      test_good();
      test_parity();
      test_frame();
      test_overflow();
      test_round_robin();
      test_glitch();
`ifdef PS2_RX_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
